// File: rtl/sevenseg_pkg.sv
// Seven-segment constants shared by the scan mux and its hex decoder.
// Patterns are active-low, bit 0 = segment a through bit 6 = segment g.
// No timing or flow control; constants and elaboration helpers only.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;  // lowercase b
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;  // lowercase d
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Index width that stays at least one bit wide for a single digit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sevenseg_scan_mux_if.sv
// Digit data in, anode/segment pins out, for the seven-segment scanner.
// Latency is owned by the scanner (one registered stage).
// No backpressure: inputs are sampled live every cycle.
interface sevenseg_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank;
    logic [3:0]            bright;
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            seg;
    logic                  dp;

    modport master (
        output digits, dp_in, blank, bright,
        input  an, seg, dp
    );

    modport slave (
        input  digits, dp_in, blank, bright,
        output an, seg, dp
    );
endinterface

// File: rtl/sevenseg_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern, full 0-F.
// Latency: combinational.  Backpressure: none.
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);
    always_comb begin
        pat = SEG_BLANK;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            4'hF: pat = SEG_F;
            default: pat = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/sevenseg_scan_mux.sv
// N-digit time-multiplexed seven-segment driver with per-digit dp and blanking.
// Latency: 1 clk from any input or digit-index change to the registered pins.
// Backpressure: none; SEVENSEG_DIM_EN adds PWM brightness within each slot.
module sevenseg_scan_mux
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV_LOG2 = 13
) (
    input logic                clk,
    input logic                rst,
    sevenseg_scan_mux_if.slave bus
);
    localparam int             IW       = idx_width(N_DIGITS);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N_DIGITS - 1);

    logic [DIV_LOG2-1:0] cnt;
    logic [IW-1:0]       idx;
    logic [3:0]          nib;
    logic [6:0]          pat;
    logic [N_DIGITS-1:0] an_pat;
    logic                blank_sel;
    logic                dp_sel;
    logic                pwm_ok;
    logic                on;

    // Explicit wrap keeps non-power-of-two digit counts off unused indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + DIV_LOG2'(1);
            if (&cnt) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    always_comb begin
        nib       = 4'h0;
        blank_sel = 1'b0;
        dp_sel    = 1'b0;
        an_pat    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = bus.digits[4*i +: 4];
                blank_sel = bus.blank[i];
                dp_sel    = bus.dp_in[i];
                an_pat[i] = 1'b0;
            end
        end
    end

    sevenseg_hex_decoder u_dec (
        .nib (nib),
        .pat (pat)
    );

`ifdef SEVENSEG_DIM_EN
    // Lit from the slot head for (bright+1)/16 of the slot.
    assign pwm_ok = (cnt[DIV_LOG2-1 -: 4] <= bus.bright);
`else
    assign pwm_ok = 1'b1;
`endif

    assign on = !blank_sel && pwm_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an  <= '1;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= on ? an_pat : '1;
            bus.seg <= on ? pat : SEG_BLANK;
            bus.dp  <= on ? ~dp_sel : 1'b1;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Directed bench for sevenseg_scan_mux: 4-digit and 3-digit instances, DIV_LOG2=4.
module tb_sevenseg_scan_mux;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    logic [6:0] exp_seg [16];

    sevenseg_scan_mux_if #(.N_DIGITS(4)) bus4 ();
    sevenseg_scan_mux_if #(.N_DIGITS(3)) bus3 ();

    sevenseg_scan_mux #(.N_DIGITS(4), .DIV_LOG2(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    sevenseg_scan_mux #(.N_DIGITS(3), .DIV_LOG2(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        int lit;
        int exp_lit;
        int e;
        logic [2:0] exp_an3;

        exp_seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;

        bus4.digits = 16'h1234;
        bus4.dp_in  = 4'b0000;
        bus4.blank  = 4'b0000;
        bus4.bright = 4'd15;
        bus3.digits = 12'h567;
        bus3.dp_in  = 3'b000;
        bus3.blank  = 3'b000;
        bus3.bright = 4'd15;

        rst = 1'b1;
        tick();
        tick();
        chk("reset_an", 16'(bus4.an), 16'hF);
        chk("reset_seg", 16'(bus4.seg), 16'h7F);
        chk("reset_dp", 16'(bus4.dp), 16'h1);
        rst = 1'b0;
        cyc = 0;

        tick_to(1);
        chk("clk1_an", 16'(bus4.an), 16'b1110);
        chk("clk1_seg", 16'(bus4.seg), 16'b0011001);
        chk("clk1_dp", 16'(bus4.dp), 16'h1);
        tick_to(16);
        chk("clk16_an", 16'(bus4.an), 16'b1110);
        tick_to(17);
        chk("clk17_an", 16'(bus4.an), 16'b1101);
        chk("clk17_seg", 16'(bus4.seg), 16'b0110000);
        tick_to(33);
        chk("clk33_an", 16'(bus4.an), 16'b1011);
        chk("clk33_seg", 16'(bus4.seg), 16'b0100100);
        tick_to(49);
        chk("clk49_an", 16'(bus4.an), 16'b0111);
        chk("clk49_seg", 16'(bus4.seg), 16'b1111001);
        tick_to(65);
        chk("clk65_an", 16'(bus4.an), 16'b1110);

        bus4.blank = 4'b0010;
        bus4.dp_in = 4'b0001;
        tick();
        chk("dp0_an", 16'(bus4.an), 16'b1110);
        chk("dp0_dp", 16'(bus4.dp), 16'h0);
        tick_to(81);
        chk("blank1_an", 16'(bus4.an), 16'b1111);
        chk("blank1_seg", 16'(bus4.seg), 16'h7F);
        chk("blank1_dp", 16'(bus4.dp), 16'h1);
        tick_to(97);
        chk("slot2_an", 16'(bus4.an), 16'b1011);
        chk("slot2_seg", 16'(bus4.seg), 16'b0100100);
        chk("slot2_dp", 16'(bus4.dp), 16'h1);
        bus4.blank = 4'b0000;
        bus4.dp_in = 4'b0000;

        bus4.digits = 16'h1F34;
        tick();
        chk("midslot_change_seg", 16'(bus4.seg), 16'b0001110);
        chk("midslot_change_an", 16'(bus4.an), 16'b1011);

`ifdef SEVENSEG_DIM_EN
        exp_lit = 16;
`else
        exp_lit = 16;
`endif
        tick_to(112);
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (bus4.an[3] == 1'b0) lit++;
        end
        chk("duty_b15", 16'(lit), 16'(exp_lit));

        bus4.bright = 4'd3;
`ifdef SEVENSEG_DIM_EN
        exp_lit = 4;
`else
        exp_lit = 16;
`endif
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (bus4.an[0] == 1'b0) lit++;
        end
        chk("duty_b3", 16'(lit), 16'(exp_lit));

        bus4.bright = 4'd0;
`ifdef SEVENSEG_DIM_EN
        exp_lit = 1;
`else
        exp_lit = 16;
`endif
        lit = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (bus4.an[1] == 1'b0) lit++;
        end
        chk("duty_b0", 16'(lit), 16'(exp_lit));
        bus4.bright = 4'd15;

        tick_to(170);
        rst = 1'b1;
        tick();
        chk("midrst_an", 16'(bus4.an), 16'hF);
        chk("midrst_seg", 16'(bus4.seg), 16'h7F);
        rst = 1'b0;
        cyc = 0;
        tick_to(1);
        chk("postrst_clk1_an", 16'(bus4.an), 16'b1110);
        chk("postrst_clk1_seg", 16'(bus4.seg), 16'b0011001);
        tick_to(16);
        chk("postrst_clk16_an", 16'(bus4.an), 16'b1110);
        tick_to(17);
        chk("postrst_clk17_an", 16'(bus4.an), 16'b1101);

        tick_to(64);
        for (int v = 0; v < 16; v++) begin
            bus4.digits[3:0] = 4'(v);
            tick();
            chk("hex_seg", 16'(bus4.seg), 16'(exp_seg[v]));
            chk("hex_an", 16'(bus4.an), 16'b1110);
        end

        while (cyc < 176) begin
            tick();
            e = ((cyc - 1) / 16) % 3;
            exp_an3 = 3'b111;
            exp_an3[e] = 1'b0;
            chk("n3_an", 16'(bus3.an), 16'(exp_an3));
            chk("n3_seg", 16'(bus3.seg), 16'(exp_seg[7 - e]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
